// File: rtl/move_input_pkg.sv
// Shared game definitions for the human-player move front end:
// board geometry, move-input FSM states and the move record.
package move_input_pkg;

    localparam int BOARD_SIZE = 15;
    localparam int IDX_W      = $clog2(BOARD_SIZE);

    // Cursor home position, used at reset
    localparam logic [IDX_W-1:0] CENTER = IDX_W'(BOARD_SIZE / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CHECK,
        S_COMMIT,
        S_WAIT_REL
    } mi_state_e;

    typedef struct packed {
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } move_t;

endpackage

// File: rtl/cursor_wrap_ctr.sv
// Modulo-N up/down counter with wrap-around in both directions.
// Opposing pulses in the same cycle cancel; the count only moves when enabled.
module cursor_wrap_ctr #(
    parameter int             N         = 15,
    parameter int             W         = $clog2(N),
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_val
);

    localparam logic [W-1:0] MAX_VAL = W'(N - 1);

    logic [W-1:0] val;
    logic [W-1:0] val_nxt;

    // Next count: one step up or down, wrapping at 0 and N-1
    always_comb begin
        // NOTE: default assignment first so every path drives val_nxt (no latch)
        val_nxt = val;
        if (i_en && (i_inc != i_dec)) begin
            if (i_inc) begin
                val_nxt = (val == MAX_VAL) ? '0 : val + 1'b1;
            end else begin
                val_nxt = (val == '0) ? MAX_VAL : val - 1'b1;
            end
        end
    end

    // Count register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            val <= RESET_VAL;
        end else begin
            // NOTE: non-blocking in clocked blocks so all registers update together
            val <= val_nxt;
        end
    end

    assign o_val = val;

endmodule

// File: rtl/move_input.sv
// Human-player front end: turns debounced button pulses into a wrapping
// board cursor, checks the target cell against the board store and hands
// one legal move per granted turn to the game Controller. Also forwards
// undo / resign requests and produces the cursor blink phase.
module move_input
    import move_input_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_turn,
    input  logic             i_up,
    input  logic             i_down,
    input  logic             i_left,
    input  logic             i_right,
    input  logic             i_confirm,
    input  logic             i_undo,
    input  logic             i_resign,
    output logic [IDX_W-1:0] o_q_row,
    output logic [IDX_W-1:0] o_q_col,
    input  logic             i_q_occupied,
    output logic [IDX_W-1:0] o_row,
    output logic [IDX_W-1:0] o_col,
    output logic             o_player_done,
    output logic             o_prestep,
    output logic             o_surrender,
    output logic [IDX_W-1:0] o_cur_row,
    output logic [IDX_W-1:0] o_cur_col,
    output logic             o_blink,
    output logic             o_reject
);

    localparam int                CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BLINK_DIV - 1);

    mi_state_e        state;
    mi_state_e        state_nxt;
    move_t            cursor;
    move_t            committed;
    logic             move_en;
    logic             moved;
    logic             req_ok;
    logic             reject_q;
    logic             prestep_q;
    logic             surrender_q;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_q;

    // Cursor only moves in SELECT; a confirm in the same cycle freezes it so
    // the check uses the position the player saw when pressing confirm.
    assign move_en = (state == S_SELECT) && !i_confirm;
    assign moved   = move_en && (i_up || i_down || i_left || i_right);

    // Undo / resign are dropped while a move is being handed over
    assign req_ok  = (state != S_COMMIT);

    cursor_wrap_ctr #(
        .N         (BOARD_SIZE),
        .W         (IDX_W),
        .RESET_VAL (CENTER)
    ) u_row_ctr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (move_en),
        .i_inc   (i_down),
        .i_dec   (i_up),
        .o_val   (cursor.row)
    );

    cursor_wrap_ctr #(
        .N         (BOARD_SIZE),
        .W         (IDX_W),
        .RESET_VAL (CENTER)
    ) u_col_ctr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (move_en),
        .i_inc   (i_right),
        .i_dec   (i_left),
        .o_val   (cursor.col)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_turn) state_nxt = S_SELECT;
            end
            S_SELECT: begin
                if (!i_turn)        state_nxt = S_IDLE;
                else if (i_confirm) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                // Board store answers one cycle after the cursor address
                state_nxt = i_q_occupied ? S_SELECT : S_COMMIT;
            end
            S_COMMIT: begin
                state_nxt = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                // Controller may hold i_turn a little longer; never issue a second move
                if (!i_turn) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM outputs: move handover strobe is high for the single COMMIT cycle
    always_comb begin
        o_player_done = (state == S_COMMIT);
    end

    // Committed move latch and one-cycle request / reject pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            committed   <= '0;
            reject_q    <= 1'b0;
            prestep_q   <= 1'b0;
            surrender_q <= 1'b0;
        end else begin
            if ((state == S_CHECK) && !i_q_occupied) begin
                committed <= cursor;
            end
            reject_q    <= (state == S_CHECK) && i_q_occupied;
            // Resign outranks undo when both arrive together
            surrender_q <= i_resign && req_ok;
            prestep_q   <= i_undo && !i_resign && req_ok;
        end
    end

    // Cursor blink: toggle every BLINK_DIV cycles, restart visible on movement
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (moved) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (blink_cnt == CNT_MAX) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign o_q_row     = cursor.row;
    assign o_q_col     = cursor.col;
    assign o_cur_row   = cursor.row;
    assign o_cur_col   = cursor.col;
    assign o_row       = committed.row;
    assign o_col       = committed.col;
    assign o_reject    = reject_q;
    assign o_prestep   = prestep_q;
    assign o_surrender = surrender_q;
    assign o_blink     = blink_q;

endmodule
